alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter WORD_W, default 32, datapath width.
REQ-002 Parameter OPT_W, default 6, opcode width (matches the shared INST_OPT_TP).
REQ-003 Parameter ROB_W, default 5, ROB index width; index 0 (ZERO_ROB_IDX) SHALL mean "no tag".
REQ-004 Parameter FIFO_DEPTH, default 4, result buffer entries, power of two.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global ready; rb  in  1  rollback/flush.
REQ-007 alu_ena  in  1  one-cycle issue strobe from the reservation station.
REQ-008 alu_opt  in  OPT_W, alu_val1/alu_val2/alu_imm  in  WORD_W, alu_rob_idx  in  ROB_W: issued operands.
REQ-009 alu_stall  out  1  backpressure to the reservation station (drives its rs_st).
REQ-010 cdb_alu_valid  out  1; cdb_alu_src  out  ROB_W; cdb_alu_val  out  WORD_W: CDB broadcast.
REQ-011 cdb_alu_gnt  in  1  CDB arbiter grant for the current broadcast.
REQ-012 ovf_err  out  1  sticky overflow-drop error flag.

Function
REQ-013 Compute combinationally on issue operands: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (operand b = val2); ADDI..SRAI (b = imm); LUI (result = imm); BEQ, BNE, BLT, BGE, BLTU, BGEU (result = 1 if taken, else 0).
REQ-014 Shift amounts SHALL use b[4:0]; SLT/BLT/BGE signed, *U variants unsigned; arithmetic wraps modulo 2^WORD_W.
REQ-015 Unknown opcode SHALL produce result 0 and still be broadcast.
REQ-016 On a clk edge with rdy=1, rb=0, alu_ena=1: {alu_rob_idx, result} SHALL be pushed to the result FIFO.
REQ-017 cdb_alu_valid SHALL equal FIFO non-empty; cdb_alu_src/val SHALL show the FIFO head; first broadcast is visible the cycle after the issue edge (latency 1).
REQ-018 Head SHALL pop on an edge with rdy=1, rb=0, cdb_alu_valid=1, cdb_alu_gnt=1; with no grant the head SHALL hold unchanged.
REQ-019 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 alu_stall SHALL be 1 when count >= FIFO_DEPTH-2 (two-entry margin for the reservation station's one-cycle issue lag).
REQ-022 Push when full with no same-cycle pop SHALL be dropped and set ovf_err until reset.
REQ-023 rdy=0 SHALL freeze all state; outputs keep their values.
REQ-024 rb=1 SHALL empty the FIFO on that edge (pointers and count to 0), discard any same-cycle issue; ovf_err retained.
REQ-025 alu_rob_idx=0 with alu_ena=1 is illegal; pushed as-is, no check.

Reset
REQ-026 rst SHALL take precedence over rb and rdy; after reset: count=0, pointers=0, cdb_alu_valid=0, cdb_alu_src=0, cdb_alu_val=0, alu_stall=0, ovf_err=0.
REQ-027 Reset mid-operation SHALL discard all buffered results with no broadcast.

Structure
REQ-028 Opcode encodings (OPT_*), WORD/ROB widths, ZERO_ROB_IDX and ZERO_WORD SHALL reside in the shared utils header.
REQ-029 The FIFO SHALL be a sub-module result_fifo (parameterized width/depth, push/pop/flush, count output); ALU datapath stays in alu_unit.

Verification
REQ-030 ADD val1=5, val2=7, rob=3, gnt=1 -> next cycle valid=1, src=3, val=12; following cycle valid=0.
REQ-031 SRA val1=0x80000000, imm=0x24 (SRAI) -> val=0xF8000000; BLTU 1 vs 0xFFFFFFFF -> val=1; BLT same operands -> val=0.
REQ-032 gnt=0, issue 3 ops (rob 1,2,3) consecutively -> alu_stall=1 after 2nd push; raise gnt -> broadcasts 1,2,3 in order, one per cycle.
REQ-033 gnt=0, 5 issues into depth 4 -> 5th dropped, ovf_err=1; FIFO holds rob of issues 1-4.
REQ-034 2 entries buffered, rb=1 with concurrent alu_ena -> next cycle valid=0, count=0.
REQ-035 1 entry buffered, rdy=0 for 3 cycles with gnt=1 -> entry held, no pop; rdy=1 -> broadcast pops.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared definitions for the integer ALU unit: opcode encodings, default widths
// and the zero constants used as "no tag" / "no value".
package alu_unit_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_OPT_W  = 6;
  localparam int DEF_ROB_W  = 5;

  localparam logic [DEF_ROB_W-1:0]  ZERO_ROB_IDX = '0;
  localparam logic [DEF_WORD_W-1:0] ZERO_WORD    = '0;

  // Opcode 0 is left unassigned so an idle/cleared opcode bus decodes as unknown.
  localparam logic [DEF_OPT_W-1:0] OPT_ADD   = 6'd1;
  localparam logic [DEF_OPT_W-1:0] OPT_SUB   = 6'd2;
  localparam logic [DEF_OPT_W-1:0] OPT_SLL   = 6'd3;
  localparam logic [DEF_OPT_W-1:0] OPT_SLT   = 6'd4;
  localparam logic [DEF_OPT_W-1:0] OPT_SLTU  = 6'd5;
  localparam logic [DEF_OPT_W-1:0] OPT_XOR   = 6'd6;
  localparam logic [DEF_OPT_W-1:0] OPT_SRL   = 6'd7;
  localparam logic [DEF_OPT_W-1:0] OPT_SRA   = 6'd8;
  localparam logic [DEF_OPT_W-1:0] OPT_OR    = 6'd9;
  localparam logic [DEF_OPT_W-1:0] OPT_AND   = 6'd10;
  localparam logic [DEF_OPT_W-1:0] OPT_ADDI  = 6'd11;
  localparam logic [DEF_OPT_W-1:0] OPT_SLTI  = 6'd12;
  localparam logic [DEF_OPT_W-1:0] OPT_SLTIU = 6'd13;
  localparam logic [DEF_OPT_W-1:0] OPT_XORI  = 6'd14;
  localparam logic [DEF_OPT_W-1:0] OPT_ORI   = 6'd15;
  localparam logic [DEF_OPT_W-1:0] OPT_ANDI  = 6'd16;
  localparam logic [DEF_OPT_W-1:0] OPT_SLLI  = 6'd17;
  localparam logic [DEF_OPT_W-1:0] OPT_SRLI  = 6'd18;
  localparam logic [DEF_OPT_W-1:0] OPT_SRAI  = 6'd19;
  localparam logic [DEF_OPT_W-1:0] OPT_LUI   = 6'd20;
  localparam logic [DEF_OPT_W-1:0] OPT_BEQ   = 6'd21;
  localparam logic [DEF_OPT_W-1:0] OPT_BNE   = 6'd22;
  localparam logic [DEF_OPT_W-1:0] OPT_BLT   = 6'd23;
  localparam logic [DEF_OPT_W-1:0] OPT_BGE   = 6'd24;
  localparam logic [DEF_OPT_W-1:0] OPT_BLTU  = 6'd25;
  localparam logic [DEF_OPT_W-1:0] OPT_BGEU  = 6'd26;

endpackage

// File: rtl/alu_unit_if.sv
// Issue and CDB bus between reservation station / CDB arbiter (master) and the ALU (slave).
interface alu_unit_if #(
  parameter int WORD_W = 32,
  parameter int OPT_W  = 6,
  parameter int ROB_W  = 5
);
  logic              alu_ena;
  logic [OPT_W-1:0]  alu_opt;
  logic [WORD_W-1:0] alu_val1;
  logic [WORD_W-1:0] alu_val2;
  logic [WORD_W-1:0] alu_imm;
  logic [ROB_W-1:0]  alu_rob_idx;
  logic              alu_stall;
  logic              cdb_alu_valid;
  logic [ROB_W-1:0]  cdb_alu_src;
  logic [WORD_W-1:0] cdb_alu_val;
  logic              cdb_alu_gnt;

  // Handshakes: an issue transfers on every edge where alu_ena=1 (alu_stall is
  // advisory backpressure with a two-entry margin, not a ready). A broadcast
  // transfers on an edge where cdb_alu_valid=1 and cdb_alu_gnt=1; while valid
  // is high without a grant, src/val hold stable. Both need rdy=1 and rb=0.
  modport master (
    output alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx, cdb_alu_gnt,
    input  alu_stall, cdb_alu_valid, cdb_alu_src, cdb_alu_val
  );

  modport slave (
    input  alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx, cdb_alu_gnt,
    output alu_stall, cdb_alu_valid, cdb_alu_src, cdb_alu_val
  );
endinterface

// File: rtl/alu_unit_result_fifo.sv
// Result FIFO for the ALU: power-of-two depth, push/pop/flush, exposes its occupancy.
module result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !flush && push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/alu_unit.sv
// Integer ALU execution unit: combinational datapath on issue, results buffered
// in a small FIFO and broadcast on the CDB in issue order.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int OPT_W      = DEF_OPT_W,
  parameter int ROB_W      = DEF_ROB_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rb,
  alu_unit_if.slave        bus,
  output logic             ovf_err,
  output logic [CNT_W-1:0] dbg_count
);
  logic [WORD_W-1:0]       op_a;
  logic [WORD_W-1:0]       op_b;
  logic [WORD_W-1:0]       result;
  logic                    lt_s;
  logic                    lt_u;
  logic                    issue;
  logic                    pop;
  logic [ROB_W+WORD_W-1:0] head;
  logic                    empty;
  logic                    full;
  logic [CNT_W-1:0]        count;

  assign op_a = bus.alu_val1;

  always_comb begin
    op_b = bus.alu_val2;
    case (bus.alu_opt)
      OPT_W'(OPT_ADDI), OPT_W'(OPT_SLTI), OPT_W'(OPT_SLTIU), OPT_W'(OPT_XORI),
      OPT_W'(OPT_ORI),  OPT_W'(OPT_ANDI), OPT_W'(OPT_SLLI),  OPT_W'(OPT_SRLI),
      OPT_W'(OPT_SRAI): op_b = bus.alu_imm;
      default: ;
    endcase
  end

  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  // Branch opcodes never select the immediate, so they compare val1 with val2.
  always_comb begin
    result = '0;
    case (bus.alu_opt)
      OPT_W'(OPT_ADD), OPT_W'(OPT_ADDI):                    result = op_a + op_b;
      OPT_W'(OPT_SUB):                                      result = op_a - op_b;
      OPT_W'(OPT_SLL), OPT_W'(OPT_SLLI):                    result = op_a << op_b[4:0];
      OPT_W'(OPT_SRL), OPT_W'(OPT_SRLI):                    result = op_a >> op_b[4:0];
      OPT_W'(OPT_SRA), OPT_W'(OPT_SRAI):                    result = $unsigned($signed(op_a) >>> op_b[4:0]);
      OPT_W'(OPT_SLT), OPT_W'(OPT_SLTI), OPT_W'(OPT_BLT):   result = WORD_W'(lt_s);
      OPT_W'(OPT_SLTU), OPT_W'(OPT_SLTIU), OPT_W'(OPT_BLTU): result = WORD_W'(lt_u);
      OPT_W'(OPT_BGE):                                      result = WORD_W'(!lt_s);
      OPT_W'(OPT_BGEU):                                     result = WORD_W'(!lt_u);
      OPT_W'(OPT_XOR), OPT_W'(OPT_XORI):                    result = op_a ^ op_b;
      OPT_W'(OPT_OR),  OPT_W'(OPT_ORI):                     result = op_a | op_b;
      OPT_W'(OPT_AND), OPT_W'(OPT_ANDI):                    result = op_a & op_b;
      OPT_W'(OPT_LUI):                                      result = bus.alu_imm;
      OPT_W'(OPT_BEQ):                                      result = WORD_W'(op_a == op_b);
      OPT_W'(OPT_BNE):                                      result = WORD_W'(op_a != op_b);
      default:                                              result = '0;
    endcase
  end

  assign issue = rdy && !rb && bus.alu_ena;
  assign pop   = rdy && !rb && !empty && bus.cdb_alu_gnt;

  // rdy gates everything, including a rollback: a stalled core holds its FIFO.
  result_fifo #(
    .W     (ROB_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (rb),
    .push  (issue),
    .pop   (pop),
    .din   ({bus.alu_rob_idx, result}),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (issue && full && !pop) begin
      ovf_err <= 1'b1;
    end
  end

  // Head data is masked while empty so a drained or reset FIFO shows zeros.
  assign bus.cdb_alu_valid = !empty;
  assign bus.cdb_alu_src   = empty ? '0 : head[WORD_W +: ROB_W];
  assign bus.cdb_alu_val   = empty ? '0 : head[WORD_W-1:0];
  assign bus.alu_stall     = (int'(count) >= FIFO_DEPTH - 2);
  assign dbg_count         = count;
endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int WORD_W = 32;
  localparam int ROB_W  = 5;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       rb;
  logic       ovf_err;
  logic [2:0] dbg_count;

  alu_unit_if #(.WORD_W(WORD_W), .OPT_W(6), .ROB_W(ROB_W)) bus ();

  alu_unit dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rb        (rb),
    .bus       (bus.slave),
    .ovf_err   (ovf_err),
    .dbg_count (dbg_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ROB_W+WORD_W-1:0] exp_q[$];
  logic                    m_ovf;
  int                      checks;
  int                      errors;

  logic [5:0] op_list [26] = '{OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR,
    OPT_SRL, OPT_SRA, OPT_OR, OPT_AND, OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI,
    OPT_ANDI, OPT_SLLI, OPT_SRLI, OPT_SRAI, OPT_LUI, OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE,
    OPT_BLTU, OPT_BGEU};

  // Reference semantics written from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] v2, input logic [31:0] imm);
    logic [31:0] b;
    logic [31:0] fill;
    int          sh;
    logic        slt;
    b = (op inside {OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
                    OPT_SLLI, OPT_SRLI, OPT_SRAI}) ? imm : v2;
    sh   = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    slt  = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    case (op)
      OPT_ADD, OPT_ADDI:              return a + b;
      OPT_SUB:                        return a - b;
      OPT_SLL, OPT_SLLI:              return a << sh;
      OPT_SRL, OPT_SRLI:              return a >> sh;
      OPT_SRA, OPT_SRAI:              return (a >> sh) | fill;
      OPT_SLT, OPT_SLTI, OPT_BLT:     return slt ? 32'd1 : 32'd0;
      OPT_SLTU, OPT_SLTIU, OPT_BLTU:  return (a < b) ? 32'd1 : 32'd0;
      OPT_BGE:                        return slt ? 32'd0 : 32'd1;
      OPT_BGEU:                       return (a >= b) ? 32'd1 : 32'd0;
      OPT_XOR, OPT_XORI:              return a ^ b;
      OPT_OR, OPT_ORI:                return a | b;
      OPT_AND, OPT_ANDI:              return a & b;
      OPT_LUI:                        return imm;
      OPT_BEQ:                        return (a == v2) ? 32'd1 : 32'd0;
      OPT_BNE:                        return (a != v2) ? 32'd1 : 32'd0;
      default:                        return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic set_idle();
    bus.alu_ena     = 1'b0;
    bus.alu_opt     = '0;
    bus.alu_val1    = '0;
    bus.alu_val2    = '0;
    bus.alu_imm     = '0;
    bus.alu_rob_idx = '0;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] v2,
                             input logic [31:0] imm, input logic [4:0] rob);
    bus.alu_ena     = 1'b1;
    bus.alu_opt     = op;
    bus.alu_val1    = a;
    bus.alu_val2    = v2;
    bus.alu_imm     = imm;
    bus.alu_rob_idx = rob;
  endtask

  // Advance one edge, updating the model from the inputs sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (rdy) begin
      if (rb) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && bus.cdb_alu_gnt) void'(exp_q.pop_front());
        if (bus.alu_ena) begin
          if (exp_q.size() == DEPTH) m_ovf = 1'b1;
          else exp_q.push_back({bus.alu_rob_idx,
                                ref_alu(bus.alu_opt, bus.alu_val1, bus.alu_val2, bus.alu_imm)});
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 6;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.cdb_alu_valid); end
    if (bus.cdb_alu_src !== 5'd0) begin errors++; $display("FAIL reset_src got %0d want 0", bus.cdb_alu_src); end
    if (bus.cdb_alu_val !== 32'd0) begin errors++; $display("FAIL reset_val got %h want 0", bus.cdb_alu_val); end
    if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.alu_stall); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf_err); end
    if (dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dbg_count); end
  endtask

  task automatic test_add();
    bus.cdb_alu_gnt = 1'b1;
    drive_issue(OPT_ADD, 32'd5, 32'd7, 32'd0, 5'd3);
    tick();
    set_idle();
    checks += 3;
    if (bus.cdb_alu_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", bus.cdb_alu_valid); end
    if (bus.cdb_alu_src !== 5'd3) begin errors++; $display("FAIL add_src got %0d want 3", bus.cdb_alu_src); end
    if (bus.cdb_alu_val !== 32'd12) begin errors++; $display("FAIL add_val got %0d want 12", bus.cdb_alu_val); end
    tick();
    checks++;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %0b want 0", bus.cdb_alu_valid); end
  endtask

  task automatic test_ops();
    bus.cdb_alu_gnt = 1'b1;
    drive_issue(OPT_SRAI, 32'h8000_0000, 32'd0, 32'h24, 5'd4);
    tick();
    checks++;
    if (bus.cdb_alu_val !== 32'hF800_0000) begin errors++; $display("FAIL srai_val got %h want f8000000", bus.cdb_alu_val); end
    drive_issue(OPT_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5);
    tick();
    checks += 2;
    if (bus.cdb_alu_src !== 5'd5) begin errors++; $display("FAIL bltu_src got %0d want 5", bus.cdb_alu_src); end
    if (bus.cdb_alu_val !== 32'd1) begin errors++; $display("FAIL bltu_val got %0d want 1", bus.cdb_alu_val); end
    drive_issue(OPT_BLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd6);
    tick();
    checks += 2;
    if (bus.cdb_alu_src !== 5'd6) begin errors++; $display("FAIL blt_src got %0d want 6", bus.cdb_alu_src); end
    if (bus.cdb_alu_val !== 32'd0) begin errors++; $display("FAIL blt_val got %0d want 0", bus.cdb_alu_val); end
    drive_issue(6'd63, 32'd9, 32'd9, 32'd9, 5'd7);
    tick();
    set_idle();
    checks += 3;
    if (bus.cdb_alu_valid !== 1'b1) begin errors++; $display("FAIL unk_valid got %0b want 1", bus.cdb_alu_valid); end
    if (bus.cdb_alu_src !== 5'd7) begin errors++; $display("FAIL unk_src got %0d want 7", bus.cdb_alu_src); end
    if (bus.cdb_alu_val !== 32'd0) begin errors++; $display("FAIL unk_val got %h want 0", bus.cdb_alu_val); end
    tick();
  endtask

  task automatic test_stall();
    bus.cdb_alu_gnt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive_issue(OPT_ADDI, 32'(k), 32'd0, 32'd100, 5'(k));
      tick();
      checks++;
      if (bus.alu_stall !== (k >= 2)) begin errors++; $display("FAIL stall_k%0d got %0b want %0b", k, bus.alu_stall, k >= 2); end
    end
    set_idle();
    bus.cdb_alu_gnt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      checks += 2;
      if (bus.cdb_alu_src !== 5'(k)) begin errors++; $display("FAIL order_src%0d got %0d want %0d", k, bus.cdb_alu_src, k); end
      if (bus.cdb_alu_val !== 32'(k + 100)) begin errors++; $display("FAIL order_val%0d got %0d want %0d", k, bus.cdb_alu_val, k + 100); end
      tick();
    end
    checks++;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL order_end got %0b want 0", bus.cdb_alu_valid); end
  endtask

  task automatic test_freeze();
    bus.cdb_alu_gnt = 1'b0;
    drive_issue(OPT_LUI, 32'd0, 32'd0, 32'hABCD_E000, 5'd9);
    tick();
    set_idle();
    bus.cdb_alu_gnt = 1'b1;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks += 3;
      if (bus.cdb_alu_valid !== 1'b1) begin errors++; $display("FAIL freeze_valid%0d got %0b want 1", c, bus.cdb_alu_valid); end
      if (bus.cdb_alu_src !== 5'd9) begin errors++; $display("FAIL freeze_src%0d got %0d want 9", c, bus.cdb_alu_src); end
      if (bus.cdb_alu_val !== 32'hABCD_E000) begin errors++; $display("FAIL freeze_val%0d got %h want abcde000", c, bus.cdb_alu_val); end
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL freeze_pop got %0b want 0", bus.cdb_alu_valid); end
  endtask

  task automatic test_overflow();
    bus.cdb_alu_gnt = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive_issue(OPT_XOR, 32'(k), 32'hFF, 32'd0, 5'(k + 10));
      tick();
    end
    set_idle();
    checks += 2;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf_err); end
    if (dbg_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", dbg_count); end
    bus.cdb_alu_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks += 2;
      if (bus.cdb_alu_src !== 5'(k + 10)) begin errors++; $display("FAIL ovf_src%0d got %0d want %0d", k, bus.cdb_alu_src, k + 10); end
      if (bus.cdb_alu_val !== (32'(k) ^ 32'hFF)) begin errors++; $display("FAIL ovf_val%0d got %h want %h", k, bus.cdb_alu_val, 32'(k) ^ 32'hFF); end
      tick();
    end
    checks++;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL ovf_drop got %0b want 0", bus.cdb_alu_valid); end
  endtask

  task automatic test_flush();
    bus.cdb_alu_gnt = 1'b0;
    drive_issue(OPT_OR, 32'd1, 32'd2, 32'd0, 5'd20);
    tick();
    drive_issue(OPT_AND, 32'd3, 32'd2, 32'd0, 5'd21);
    tick();
    drive_issue(OPT_SUB, 32'd3, 32'd2, 32'd0, 5'd22);
    rb = 1'b1;
    tick();
    rb = 1'b0;
    set_idle();
    checks += 3;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.cdb_alu_valid); end
    if (dbg_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", dbg_count); end
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got %0b want 1", ovf_err); end
  endtask

  task automatic test_mid_reset();
    bus.cdb_alu_gnt = 1'b0;
    drive_issue(OPT_SLL, 32'd1, 32'd4, 32'd0, 5'd25);
    tick();
    drive_issue(OPT_SRL, 32'd64, 32'd2, 32'd0, 5'd26);
    tick();
    set_idle();
    bus.cdb_alu_gnt = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b want 0", bus.cdb_alu_valid); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %0b want 0", ovf_err); end
    if (dbg_count !== 3'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", dbg_count); end
    tick();
    checks++;
    if (bus.cdb_alu_valid !== 1'b0) begin errors++; $display("FAIL mrst_quiet got %0b want 0", bus.cdb_alu_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = (c == 200);
      rdy = ($urandom_range(0, 7) != 0);
      rb  = ($urandom_range(0, 31) == 0);
      bus.cdb_alu_gnt = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_issue(($urandom_range(0, 15) == 0) ? 6'(27 + $urandom_range(0, 36)) : op_list[$urandom_range(0, 25)],
                    ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom,
                    ($urandom_range(0, 3) == 0) ? bus.alu_val1 : $urandom,
                    $urandom, 5'($urandom_range(1, 31)));
      end else begin
        set_idle();
      end
      tick();
      checks += 4;
      if (bus.cdb_alu_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, bus.cdb_alu_valid, exp_q.size() > 0); end
      if (bus.alu_stall !== (exp_q.size() >= DEPTH - 2)) begin errors++; $display("FAIL rnd_stall c%0d got %0b want %0b", c, bus.alu_stall, exp_q.size() >= DEPTH - 2); end
      if (ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %0b want %0b", c, ovf_err, m_ovf); end
      if (dbg_count !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, dbg_count, exp_q.size()); end
      if (exp_q.size() > 0) begin
        checks++;
        if ({bus.cdb_alu_src, bus.cdb_alu_val} !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_head c%0d got %0d/%h want %0d/%h", c, bus.cdb_alu_src, bus.cdb_alu_val,
                   exp_q[0][WORD_W +: ROB_W], exp_q[0][WORD_W-1:0]);
        end
      end
    end
    rst = 1'b0;
    rdy = 1'b1;
    rb  = 1'b0;
    set_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf  = 1'b0;
    rst    = 1'b1;
    rdy    = 1'b1;
    rb     = 1'b0;
    bus.cdb_alu_gnt = 1'b0;
    set_idle();
    test_reset();
    test_add();
    test_ops();
    test_stall();
    test_freeze();
    test_overflow();
    test_flush();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
